// File: rtl/msrr8_seq.sv
// msrr8_seq: command sequencer for one MSRR8 multi-mode shift/rotate register.
//
// Commands arrive over a valid/ready handshake. Each one becomes per-cycle
// mode/sIn/inz drive toward the register. A one-cycle response then returns
// the register contents.
//
// Ports
//   clk        rising-edge clock shared with the MSRR8 instance
//   Re         synchronous active-high reset; it also resets the MSRR8
//   cmd_valid  command present
//   cmd_ready  command can be accepted (IDLE and not in reset)
//   cmd_op     00 LOAD, 01 ROTATE, 10 CLEAR, 11 SHL
//   cmd_data   LOAD byte
//   cmd_cnt    ROTATE/SHL step count (0..W-1)
//   sr_mode    MSRR8 mode: 00 hold, 01 shr, 10 shl, 11 ror
//   sr_sIn     MSRR8 serial input
//   sr_inz     MSRR8 synchronous zero
//   sr_Q       MSRR8 parallel output
//   rsp_valid  one-cycle completion pulse
//   rsp_data   sr_Q captured at completion; held until the next completion
//   busy       state is not IDLE
//   err        sticky shadow-model mismatch
//
// Optional build macro: MSRR8_SEQ_CHECK_EN adds an internal shadow copy of
// the register. sr_Q is compared against it in RESP. Without the macro,
// err is tied low.

module msrr8_seq #(
  parameter int unsigned W = 8
) (
  input  logic                 clk,
  input  logic                 Re,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [W-1:0]         cmd_data,
  input  logic [$clog2(W)-1:0] cmd_cnt,
  output logic [1:0]           sr_mode,
  output logic                 sr_sIn,
  output logic                 sr_inz,
  input  logic [W-1:0]         sr_Q,
  output logic                 rsp_valid,
  output logic [W-1:0]         rsp_data,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned IW = $clog2(W);
  localparam int unsigned CW = $clog2(W) + 1;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ROT   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_SHL   = 2'b11;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_ROR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_ROT,
    S_SHL,
    S_RESP
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   data_q, data_d;
  logic [1:0]     mode_q, mode_d;
  logic           sin_q, sin_d;
  logic           inz_q, inz_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic           busy_q, busy_d;
  logic           accept;

`ifdef MSRR8_SEQ_CHECK_EN
  logic [W-1:0]   model_q, model_d;
  logic           err_q, err_d;
`endif

  assign cmd_ready = (state_q == S_IDLE) && !Re;
  assign accept    = cmd_valid && cmd_ready;

  // Next-state logic. The next-cycle drive is computed from state_d, so the
  // outputs come straight from registers and line up with the state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data_q;
    mode_d      = MODE_HOLD;
    sin_d       = 1'b0;
    inz_d       = 1'b0;
    rsp_valid_d = 1'b0;
    busy_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d = cmd_data;
          unique case (cmd_op)
            OP_LOAD: begin
              cnt_d   = CW'(W);
              state_d = S_LOAD;
            end
            OP_CLEAR: begin
              cnt_d   = CW'(1);
              state_d = S_CLR;
            end
            OP_ROT: begin
              cnt_d   = CW'(cmd_cnt);
              state_d = (cmd_cnt == '0) ? S_RESP : S_ROT;
            end
            OP_SHL: begin
              cnt_d   = CW'(cmd_cnt);
              state_d = (cmd_cnt == '0) ? S_RESP : S_SHL;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_CLR, S_LOAD, S_ROT, S_SHL: begin
        // cnt_q holds the steps still to do, including the current one.
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_data_d = sr_Q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Drive for the cycle that state_d will occupy.
    unique case (state_d)
      S_LOAD: begin
        mode_d = MODE_SHR;
        // LSB enters first and ends in bit 0 after W right shifts.
        sin_d  = data_d[IW'(CW'(W) - cnt_d)];
      end
      S_ROT:   mode_d = MODE_ROR;
      S_SHL:   mode_d = MODE_SHL;
      S_CLR:   inz_d  = 1'b1;
      default: mode_d = MODE_HOLD;
    endcase

    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (Re) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      mode_q      <= MODE_HOLD;
      sin_q       <= 1'b0;
      inz_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      sin_q       <= sin_d;
      inz_q       <= inz_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

`ifdef MSRR8_SEQ_CHECK_EN
  // Shadow register. It follows the same drive that the MSRR8 samples on each edge.
  always_comb begin
    model_d = model_q;
    err_d   = err_q;
    if (inz_q) begin
      model_d = '0;
    end else begin
      unique case (mode_q)
        MODE_SHR: model_d = {sin_q, model_q[W-1:1]};
        MODE_SHL: model_d = {model_q[W-2:0], sin_q};
        MODE_ROR: model_d = {model_q[0], model_q[W-1:1]};
        default:  model_d = model_q;
      endcase
    end
    if ((state_q == S_RESP) && (sr_Q != model_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Re) begin
      model_q <= '0;
      err_q   <= 1'b0;
    end else begin
      model_q <= model_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign sr_mode   = mode_q;
  assign sr_sIn    = sin_q;
  assign sr_inz    = inz_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_msrr8_seq.sv
// Directed bench for msrr8_seq. A behavioural MSRR8 drives sr_Q.
// An optional stuck-at-0 on bit 2 of sr_Q exercises the mismatch flag.
module tb_msrr8_seq;

  logic       clk = 1'b0;
  logic       Re;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [2:0] cmd_cnt;
  logic [1:0] sr_mode;
  logic       sr_sIn;
  logic       sr_inz;
  logic [7:0] sr_Q;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       err;

  logic [7:0] reg_q;
  logic       stuck;
  int         vectors     = 0;
  int         miscompares = 0;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ROT   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_SHL   = 2'b11;

`ifdef MSRR8_SEQ_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  // Behavioural MSRR8. It is reset by the same Re as the sequencer.
  always_ff @(posedge clk) begin
    if (Re)          reg_q <= 8'h00;
    else if (sr_inz) reg_q <= 8'h00;
    else begin
      case (sr_mode)
        2'b01:   reg_q <= {sr_sIn, reg_q[7:1]};
        2'b10:   reg_q <= {reg_q[6:0], sr_sIn};
        2'b11:   reg_q <= {reg_q[0], reg_q[7:1]};
        default: reg_q <= reg_q;
      endcase
    end
  end

  assign sr_Q = stuck ? (reg_q & 8'hFB) : reg_q;

  msrr8_seq #(.W(8)) dut (
    .clk       (clk),
    .Re        (Re),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_cnt   (cmd_cnt),
    .sr_mode   (sr_mode),
    .sr_sIn    (sr_sIn),
    .sr_inz    (sr_inz),
    .sr_Q      (sr_Q),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one command from IDLE. Measure the cycles from the accept edge to
  // rsp_valid, then check the captured data in the following cycle.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] d,
                         input logic [2:0] c, input int exp_lat,
                         input logic [1:0] exp_mode, input logic [7:0] exp_data);
    int lat;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_cnt   = c;
    check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check({tag, ".mode1"}, 32'(sr_mode), 32'(exp_mode));
    check({tag, ".inz1"}, 32'(sr_inz), 32'(op == OP_CLEAR));
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    tick();
    check({tag, ".data"}, 32'(rsp_data), 32'(exp_data));
    check({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int ready_cnt;
    int pulse_cnt;

    Re        = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
    cmd_cnt   = 3'd0;
    stuck     = 1'b0;
    @(negedge clk);
    tick();

    // Reset state
    check("rst.busy",      32'(busy),      32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_data",  32'(rsp_data),  32'h00);
    check("rst.mode",      32'(sr_mode),   32'd0);
    check("rst.sin",       32'(sr_sIn),    32'd0);
    check("rst.inz",       32'(sr_inz),    32'd0);
    check("rst.err",       32'(err),       32'd0);
    check("rst.ready_in_reset", 32'(cmd_ready), 32'd0);
    Re = 1'b0;
    #1;
    check("rst.ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // LOAD A5
    run_cmd("ldA5", OP_LOAD, 8'hA5, 3'd0, 9, 2'b01, 8'hA5);
    check("ldA5.err", 32'(err), 32'd0);

    // LOAD 81, ROTATE 3 -> 30, ROTATE 0 -> 30 in one cycle
    run_cmd("ld81", OP_LOAD, 8'h81, 3'd0, 9, 2'b01, 8'h81);
    run_cmd("rot3", OP_ROT,  8'h00, 3'd3, 4, 2'b11, 8'h30);
    run_cmd("rot0", OP_ROT,  8'h00, 3'd0, 1, 2'b00, 8'h30);

    // LOAD FF, SHL 4 -> F0, CLEAR -> 00
    run_cmd("ldFF",  OP_LOAD,  8'hFF, 3'd0, 9, 2'b01, 8'hFF);
    run_cmd("shl4",  OP_SHL,   8'h00, 3'd4, 5, 2'b10, 8'hF0);
    run_cmd("clear", OP_CLEAR, 8'h00, 3'd0, 2, 2'b00, 8'h00);
    run_cmd("shl0",  OP_SHL,   8'h00, 3'd0, 1, 2'b00, 8'h00);

    // cmd_valid held: the second command is accepted only after RESP
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_data  = 8'h5A;
    cmd_cnt   = 3'd0;
    tick();
    cmd_op    = OP_CLEAR;
    busy_cnt  = 0;
    ready_cnt = 0;
    for (int i = 1; i <= 9; i++) begin
      if (busy) busy_cnt++;
      if (cmd_ready) ready_cnt++;
      if (i == 9) check("b2b.resp_at_9", 32'(rsp_valid), 32'd1);
      tick();
    end
    check("b2b.busy_cycles", 32'(busy_cnt), 32'd9);
    check("b2b.ready_while_busy", 32'(ready_cnt), 32'd0);
    check("b2b.idle_busy",  32'(busy),      32'd0);
    check("b2b.idle_ready", 32'(cmd_ready), 32'd1);
    check("b2b.data1",      32'(rsp_data),  32'h5A);
    tick();
    cmd_valid = 1'b0;
    check("b2b.second_busy", 32'(busy),   32'd1);
    check("b2b.second_inz",  32'(sr_inz), 32'd1);
    tick();
    check("b2b.second_resp", 32'(rsp_valid), 32'd1);
    tick();
    check("b2b.data2", 32'(rsp_data), 32'h00);

    // Reset at step 4 of LOAD 3C
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_data  = 8'h3C;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort.mid_busy", 32'(busy), 32'd1);
    Re = 1'b1;
    tick();
    check("abort.busy",      32'(busy),      32'd0);
    check("abort.mode",      32'(sr_mode),   32'd0);
    check("abort.sin",       32'(sr_sIn),    32'd0);
    check("abort.inz",       32'(sr_inz),    32'd0);
    check("abort.rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort.rsp_data",  32'(rsp_data),  32'h00);
    check("abort.err",       32'(err),       32'd0);
    Re = 1'b0;
    #1;
    check("abort.ready", 32'(cmd_ready), 32'd1);
    pulse_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) pulse_cnt++;
    end
    check("abort.no_resp", 32'(pulse_cnt), 32'd0);

    // Stuck-at-0 on sr_Q[2] during LOAD 04
    stuck = 1'b1;
    run_cmd("stuck", OP_LOAD, 8'h04, 3'd0, 9, 2'b01, 8'h00);
    check("stuck.err", 32'(err), 32'(EXP_ERR));
    stuck = 1'b0;
    run_cmd("after", OP_CLEAR, 8'h00, 3'd0, 2, 2'b00, 8'h00);
    check("after.err_sticky", 32'(err), 32'(EXP_ERR));
    Re = 1'b1;
    tick();
    Re = 1'b0;
    check("err_cleared", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
